fmad: RTL and testbench
=======================

FMAD -- requirements
Module: fmad

Interface
REQ-001 Parameter WIDTH, default 8, multiplier operand width in bits.
REQ-002 Parameter OUTWIDTH, default 2*WIDTH, addend/result width; derived, not overridden independently.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 start  input  1  request; sampled high in IDLE launches one operation.
REQ-006 fmadMulIn1  input  WIDTH  unsigned multiplicand.
REQ-007 fmadMulIn2  input  WIDTH  unsigned multiplier.
REQ-008 fmadAddIn  input  OUTWIDTH  addend, two's complement bit pattern.
REQ-009 sub  input  1  0 = product + addend; 1 = product - addend.
REQ-010 negate  input  1  1 = two's complement negate the final sum.
REQ-011 fmadOut  output  OUTWIDTH  result, two's complement.
REQ-012 fmadDone  output  1  one-cycle completion pulse.

Function
REQ-013 Result SHALL be R = (negate ? -1 : 1) * (fmadMulIn1 * fmadMulIn2 + (sub ? -fmadAddIn : fmadAddIn)), modulo 2^OUTWIDTH.
- Multiply unsigned; full product always fits OUTWIDTH bits.
- Add/subtract/negate wrap silently; no overflow flag.
REQ-014 All operands and sub/negate SHALL be latched on the edge sampling start=1 in IDLE; later input changes do not affect the operation.
REQ-015 States IDLE, MUL, ADD, DONE.
- IDLE -> MUL on start=1; else stay.
- MUL: one shift-add step per cycle (multiplier LSB first); exactly WIDTH cycles, then ADD.
- ADD: compute sum, difference and optional negation; register into fmadOut; go to DONE.
- DONE: fmadDone=1 for exactly one cycle; go to IDLE.
REQ-016 fmadDone SHALL go high after the (WIDTH+2)th rising edge counting the start-sampling edge as edge 1, i.e. WIDTH+2 cycles of latency (10 for WIDTH=8).
REQ-017 fmadDone SHALL be low in IDLE, MUL and ADD.
REQ-018 fmadOut SHALL change only on the ADD->DONE edge, holding the previous result until the next operation completes.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 start held high through DONE SHALL launch a new operation from IDLE on the following sampled edge.
REQ-021 Back-to-back operations SHALL require no idle gap beyond the one IDLE cycle.

Reset
REQ-022 While reset=0, the block SHALL immediately enter IDLE, asynchronously to clock.
REQ-023 While reset=0: fmadOut=0, fmadDone=0, and the internal accumulator, counter and latched operands are 0.
REQ-024 Reset asserted mid-operation SHALL abort it with no done pulse.
REQ-025 The first start after reset release SHALL be sampled on the first rising edge with reset=1.

Structure
REQ-026 Package fmad_pkg SHALL hold the state enum (IDLE, MUL, ADD, DONE) and a localparam helper for OUTWIDTH.
REQ-027 Sub-module fmad_mul SHALL implement the sequential shift-add multiplier, with ports load, busy and product.
REQ-028 fmad SHALL contain the FSM, operand latches and add/negate datapath.

Verification
REQ-029 WIDTH=8: 3*5, addend 7, sub=0, negate=0 -> fmadOut 22 (0x0016), fmadDone pulse 10 cycles after start.
REQ-030 3*5, addend 7, sub=1, negate=0 -> 8; same operands with sub=0, negate=1 -> 0xFFEA (-22).
REQ-031 2*3, addend 10, sub=1, negate=1 -> 4; sub=1, negate=0 -> 0xFFFC (-4).
REQ-032 255*255, addend 0xFFFF, sub=0 -> 0xFE00 (wrap); 0*0, addend 0, negate=1 -> 0.
REQ-033 Mid-operation checks:
- start pulsed again during MUL, with changed operands -> ignored; the original result completes.
- reset=0 at cycle 4 -> fmadOut=0 immediately, no fmadDone, and the next operation is correct.
REQ-034 100 random operand sets covering all four sub/negate combinations -> every result matches the REQ-013 reference model.

Source files
------------

// File: rtl/fmad_pkg.sv
// Shared types and sizing helpers for the fused multiply-add/subtract block.
package fmad_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_e;

  // The full unsigned product of two WIDTH-bit operands always fits in 2*WIDTH bits.
  function automatic int out_width(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/fmad_mul.sv
// Sequential shift-add multiplier: one partial product per cycle, multiplier LSB first.
module fmad_mul
  import fmad_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int OUTWIDTH = out_width(WIDTH)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic                busy,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic [OUTWIDTH-1:0] product
);

  logic [OUTWIDTH-1:0] acc_q, acc_d;
  logic [OUTWIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (load) begin
      acc_d    = '0;
      mcand_d  = OUTWIDTH'(a);
      mplier_d = b;
    end else if (busy) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign product = acc_q;

endmodule

// File: rtl/fmad.sv
// Fused multiply-add: R = +/-(a*b +/- addend) mod 2^OUTWIDTH, WIDTH+2 cycles start-to-done.
//   state | meaning
//   IDLE  | waiting for start; operands latched on the start edge
//   MUL   | WIDTH shift-add steps in fmad_mul
//   ADD   | add/subtract addend, optional negate, register result
//   DONE  | one-cycle fmadDone pulse
module fmad
  import fmad_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int OUTWIDTH = out_width(WIDTH)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH-1:0]    fmadMulIn1,
  input  logic [WIDTH-1:0]    fmadMulIn2,
  input  logic [OUTWIDTH-1:0] fmadAddIn,
  input  logic                sub,
  input  logic                negate,
  output logic [OUTWIDTH-1:0] fmadOut,
  output logic                fmadDone
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic [OUTWIDTH-1:0] addend_q;
  logic                sub_q;
  logic                neg_q;
  logic [OUTWIDTH-1:0] out_q;
  logic                done_q;

  logic                load;
  logic                busy;
  logic [OUTWIDTH-1:0] product;
  logic [OUTWIDTH-1:0] sum_d;
  logic [OUTWIDTH-1:0] out_d;

  assign load = (state_q == IDLE) && start;
  assign busy = (state_q == MUL);

  fmad_mul #(
    .WIDTH   (WIDTH),
    .OUTWIDTH(OUTWIDTH)
  ) u_mul (
    .clock  (clock),
    .reset  (reset),
    .load   (load),
    .busy   (busy),
    .a      (fmadMulIn1),
    .b      (fmadMulIn2),
    .product(product)
  );

  always_comb begin
    sum_d = sub_q ? (product - addend_q) : (product + addend_q);
    out_d = neg_q ? (~sum_d + OUTWIDTH'(1)) : sum_d;
  end

  // cnt_q counts remaining MUL steps; leaving on zero gives exactly WIDTH MUL cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addend_q <= '0;
      sub_q    <= 1'b0;
      neg_q    <= 1'b0;
      out_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            addend_q <= fmadAddIn;
            sub_q    <= sub;
            neg_q    <= negate;
            cnt_q    <= CW'(WIDTH - 1);
            state_q  <= MUL;
          end
        end
        MUL: begin
          if (cnt_q == '0) state_q <= ADD;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        ADD: begin
          out_q   <= out_d;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fmadOut  = out_q;
  assign fmadDone = done_q;

endmodule

// File: tb/tb_fmad.sv
// Scoreboard bench for fmad: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_fmad;

  localparam int W  = 8;
  localparam int OW = 16;

  logic          clock  = 1'b0;
  logic          reset  = 1'b0;
  logic          start  = 1'b0;
  logic [W-1:0]  in1    = '0;
  logic [W-1:0]  in2    = '0;
  logic [OW-1:0] addin  = '0;
  logic          sub    = 1'b0;
  logic          negate = 1'b0;
  logic [OW-1:0] fmadOut;
  logic          fmadDone;

  typedef struct {
    logic [OW-1:0] res;
    int            issue;
    string         name;
  } exp_t;

  exp_t          sb[$];
  int            cyc      = 0;
  int            n_pass   = 0;
  int            n_total  = 0;
  logic [OW-1:0] last_res = '0;
  logic          done_prev = 1'b0;

  fmad #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .fmadMulIn1(in1),
    .fmadMulIn2(in2),
    .fmadAddIn (addin),
    .sub       (sub),
    .negate    (negate),
    .fmadOut   (fmadOut),
    .fmadDone  (fmadDone)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    exp_t e;
    if (fmadDone === 1'b1) begin
      check_int("done_width", int'(done_prev), 0);
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: got a pulse with out 0x%h, expected none (cycle %0d)", fmadOut, cyc);
      end else begin
        e = sb.pop_front();
        check(e.name, fmadOut, e.res);
        check_int({e.name, "_latency"}, cyc - e.issue + 1, W + 2);
      end
    end
    done_prev = fmadDone;
  end

  task automatic wait_done(input string name);
    int k = 0;
    while (fmadDone !== 1'b1 && k < 40) begin
      @(negedge clock);
      k++;
    end
    if (k >= 40) begin
      n_total++;
      $display("FAIL %s_timeout: no fmadDone within 40 cycles, expected one", name);
      sb.delete();
    end
    @(negedge clock);
  endtask

  // Called on a negedge with the DUT in IDLE.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [OW-1:0] ad,
                    input logic s, input logic n, input logic [OW-1:0] exp, input string name);
    in1 = a; in2 = b; addin = ad; sub = s; negate = n; start = 1'b1;
    sb.push_back('{exp, cyc + 1, name});
    @(negedge clock);
    start = 1'b0;
    in1 = W'($urandom); in2 = W'($urandom); addin = OW'($urandom);
    sub = ~s; negate = ~n;
    check({name, "_hold"}, fmadOut, last_res);
    check({name, "_done_low"}, OW'(fmadDone), '0);
    wait_done(name);
    last_res = exp;
  endtask

  function automatic logic [OW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [OW-1:0] ad, input logic s, input logic n);
    logic [OW-1:0] p, t;
    p = OW'(a) * OW'(b);
    t = s ? p - ad : p + ad;
    return n ? OW'(0) - t : t;
  endfunction

  initial begin
    #3;
    check("reset_out", fmadOut, '0);
    check("reset_done", OW'(fmadDone), '0);
    @(negedge clock);
    check("reset_out_after_edge", fmadOut, '0);
    reset = 1'b1;

    op(8'd3,   8'd5,   16'd7,      1'b0, 1'b0, 16'h0016, "add_22");
    op(8'd3,   8'd5,   16'd7,      1'b1, 1'b0, 16'h0008, "sub_8");
    op(8'd3,   8'd5,   16'd7,      1'b0, 1'b1, 16'hFFEA, "neg_m22");
    op(8'd2,   8'd3,   16'd10,     1'b1, 1'b1, 16'h0004, "subneg_4");
    op(8'd2,   8'd3,   16'd10,     1'b1, 1'b0, 16'hFFFC, "sub_m4");
    op(8'd255, 8'd255, 16'hFFFF,   1'b0, 1'b0, 16'hFE00, "wrap");
    op(8'd0,   8'd0,   16'd0,      1'b0, 1'b1, 16'h0000, "zero_neg");

    // start re-pulsed with new operands during MUL must be ignored
    in1 = 8'd3; in2 = 8'd5; addin = 16'd7; sub = 1'b0; negate = 1'b0; start = 1'b1;
    sb.push_back('{16'h0016, cyc + 1, "ignore_start"});
    @(negedge clock); start = 1'b0;
    @(negedge clock); @(negedge clock);
    in1 = 8'd9; in2 = 8'd9; addin = 16'd1; sub = 1'b1; negate = 1'b1; start = 1'b1;
    @(negedge clock); start = 1'b0;
    wait_done("ignore_start");
    last_res = 16'h0016;

    // start held through DONE launches the next op from IDLE with no extra gap
    in1 = 8'd3; in2 = 8'd5; addin = 16'd7; sub = 1'b1; negate = 1'b0; start = 1'b1;
    sb.push_back('{16'h0008, cyc + 1, "b2b_first"});
    @(negedge clock);
    begin
      int k = 0;
      while (fmadDone !== 1'b1 && k < 40) begin @(negedge clock); k++; end
      if (k >= 40) begin
        n_total++;
        $display("FAIL b2b_first_timeout: no fmadDone within 40 cycles, expected one");
      end
    end
    in1 = 8'd2; in2 = 8'd3; addin = 16'd10; sub = 1'b1; negate = 1'b1;
    sb.push_back('{16'h0004, cyc + 2, "b2b_second"});
    @(negedge clock); @(negedge clock);
    start = 1'b0;
    wait_done("b2b_second");
    last_res = 16'h0004;

    // reset in the middle of MUL aborts with no done pulse
    in1 = 8'd7; in2 = 8'd7; addin = 16'd1; sub = 1'b0; negate = 1'b0; start = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock); @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("abort_out_zero", fmadOut, '0);
    check("abort_done_low", OW'(fmadDone), '0);
    repeat (12) @(negedge clock);
    check("abort_out_held", fmadOut, '0);
    last_res = '0;
    reset = 1'b1;
    op(8'd3, 8'd5, 16'd7, 1'b0, 1'b0, 16'h0016, "after_reset");

    for (int i = 0; i < 100; i++) begin
      logic [W-1:0]  a, b;
      logic [OW-1:0] ad;
      logic          s, n;
      a  = W'($urandom_range(0, 255));
      b  = W'($urandom_range(0, 255));
      ad = OW'($urandom_range(0, 65535));
      s  = i[0];
      n  = i[1];
      op(a, b, ad, s, n, model(a, b, ad, s, n), "random");
    end

    repeat (3) @(negedge clock);
    check_int("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
